// File: rtl/spi_pwm_regctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : spi_pwm_regctl_if                                                 |
// | Brief  : Byte-level link between the SPI shifter and the register control. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface spi_pwm_regctl_if;
  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_valid;

  modport master (
    output cs_n,
    output rx_valid,
    output rx_byte,
    input  tx_byte,
    input  tx_valid
  );

  modport slave (
    input  cs_n,
    input  rx_valid,
    input  rx_byte,
    output tx_byte,
    output tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/spi_pwm_regctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : spi_pwm_regctl                                                    |
// | Brief  : SPI command decoder with shadow/active PWM registers, committed   |
// |          at PWM period end. Optional SPI_PWM_AUTOINC_EN: burst addressing. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module spi_pwm_regctl (
  input  logic                   clk,
  input  logic                   rst,
  spi_pwm_regctl_if.slave        spi,
  input  logic                   cfg_commit,
  output logic [3:0]             pwm_en,
  output logic [7:0]             pwm_period,
  output logic [31:0]            pwm_duty,
  output logic                   cmd_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [7:0] c_id_value     = 8'h96;
  localparam logic [7:0] c_period_reset = 8'hFF;
  localparam logic [2:0] c_addr_status  = 3'd6;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_addr;
  logic [2:0]  w_addr_nxt;

  logic [3:0]  r_ctrl;
  logic [7:0]  r_period;
  logic [7:0]  r_duty [4];
  logic        r_pending;
  logic [3:0]  r_err_cnt;

  logic [3:0]  r_act_en;
  logic [7:0]  r_act_period;
  logic [31:0] r_act_duty;

  logic [7:0]  r_tx_byte;
  logic        r_tx_valid;
  logic        r_cmd_err;

  logic        w_wr_en;
  logic        w_wr_hit;
  logic        w_rd_load;
  logic [2:0]  w_rd_addr;
  logic [7:0]  w_rd_data;
  logic        w_cmd_bad;

  // Next-state / control decode; cs_n high always wins and drops any byte.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_wr_en     = 1'b0;
    w_rd_load   = 1'b0;
    w_rd_addr   = r_addr;
    w_cmd_bad   = 1'b0;
    if (spi.cs_n) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_CMD;
        end
        ST_CMD: begin
          if (spi.rx_valid) begin
            w_addr_nxt = spi.rx_byte[2:0];
            w_rd_addr  = spi.rx_byte[2:0];
            if (spi.rx_byte[6:3] != 4'd0) begin
              w_cmd_bad   = 1'b1;
              w_state_nxt = ST_DRAIN;
            end else if (spi.rx_byte[7]) begin
              w_state_nxt = ST_WDATA;
            end else begin
              w_state_nxt = ST_RDATA;
              w_rd_load   = 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (spi.rx_valid) begin
            w_wr_en = 1'b1;
`ifdef SPI_PWM_AUTOINC_EN
            w_addr_nxt = r_addr + 3'd1;
`else
            w_state_nxt = ST_DRAIN;
`endif
          end
        end
        ST_RDATA: begin
          if (spi.rx_valid) begin
`ifdef SPI_PWM_AUTOINC_EN
            w_addr_nxt = r_addr + 3'd1;
            w_rd_addr  = w_addr_nxt;
            w_rd_load  = 1'b1;
`else
            w_state_nxt = ST_DRAIN;
`endif
          end
        end
        ST_DRAIN: begin
          w_state_nxt = ST_DRAIN;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // STATUS and ID are read-only, so only addresses 0..5 take writes.
  assign w_wr_hit = w_wr_en && (r_addr < c_addr_status);

  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      3'd0:    w_rd_data = {4'b0000, r_ctrl};
      3'd1:    w_rd_data = r_period;
      3'd2:    w_rd_data = r_duty[0];
      3'd3:    w_rd_data = r_duty[1];
      3'd4:    w_rd_data = r_duty[2];
      3'd5:    w_rd_data = r_duty[3];
      3'd6:    w_rd_data = {r_pending, 3'b000, r_err_cnt};
      default: w_rd_data = c_id_value;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl       <= 4'd0;
      r_period     <= c_period_reset;
      for (int i = 0; i < 4; i++) begin
        r_duty[i] <= 8'h00;
      end
      r_pending    <= 1'b0;
      r_err_cnt    <= 4'd0;
      r_act_en     <= 4'd0;
      r_act_period <= c_period_reset;
      r_act_duty   <= 32'd0;
      r_tx_byte    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;

      if (w_rd_load) begin
        r_tx_byte  <= w_rd_data;
        r_tx_valid <= 1'b1;
      end else if (spi.cs_n || (w_state_nxt == ST_DRAIN)) begin
        r_tx_byte <= 8'h00;
      end

      // Commit samples the shadow before any same-edge write lands; the
      // write below then re-arms pending so the new value goes next period.
      if (cfg_commit && r_pending) begin
        r_act_en     <= r_ctrl;
        r_act_period <= r_period;
        r_act_duty   <= {r_duty[3], r_duty[2], r_duty[1], r_duty[0]};
        r_pending    <= 1'b0;
      end

      if (w_wr_hit) begin
        r_pending <= 1'b1;
        case (r_addr)
          3'd0:    r_ctrl    <= spi.rx_byte[3:0];
          3'd1:    r_period  <= spi.rx_byte;
          3'd2:    r_duty[0] <= spi.rx_byte;
          3'd3:    r_duty[1] <= spi.rx_byte;
          3'd4:    r_duty[2] <= spi.rx_byte;
          default: r_duty[3] <= spi.rx_byte;
        endcase
      end

      if (w_cmd_bad) begin
        r_cmd_err <= 1'b1;
        if (r_err_cnt != 4'hF) begin
          r_err_cnt <= r_err_cnt + 4'd1;
        end
      end
    end
  end

  assign spi.tx_byte  = r_tx_byte;
  assign spi.tx_valid = r_tx_valid;
  assign pwm_en       = r_act_en;
  assign pwm_period   = r_act_period;
  assign pwm_duty     = r_act_duty;
  assign cmd_err      = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_pwm_regctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_spi_pwm_regctl                                                 |
// | Brief  : Directed self-checking bench for spi_pwm_regctl.                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_spi_pwm_regctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_commit;
  logic [3:0]  pwm_en;
  logic [7:0]  pwm_period;
  logic [31:0] pwm_duty;
  logic        cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  spi_pwm_regctl_if bus ();

  spi_pwm_regctl dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (bus),
    .cfg_commit (cfg_commit),
    .pwm_en     (pwm_en),
    .pwm_period (pwm_period),
    .pwm_duty   (pwm_duty),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    tick();
  endtask

  task automatic cs_high();
    bus.cs_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    cs_low();
    send_byte({1'b1, 4'b0000, a});
    send_byte(d);
    cs_high();
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    cs_low();
    send_byte({5'b00000, a});
    d = bus.tx_byte;
    check_val($sformatf("rd%0d_tx_valid", a), {31'd0, bus.tx_valid}, 32'd1);
    cs_high();
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    rst          = 1'b1;
    bus.cs_n     = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h85;
    cfg_commit   = 1'b1;
    repeat (3) tick();
    bus.cs_n     = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    cfg_commit   = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_en",       {28'd0, pwm_en}, 32'h0);
    check_val("rst_period",   {24'd0, pwm_period}, 32'hFF);
    check_val("rst_duty",     pwm_duty, 32'h0);
    check_val("rst_tx_byte",  {24'd0, bus.tx_byte}, 32'h0);
    check_val("rst_tx_valid", {31'd0, bus.tx_valid}, 32'h0);
    check_val("rst_cmd_err",  {31'd0, cmd_err}, 32'h0);

    // ID / PERIOD / STATUS reads after reset
    read_reg(3'd7, rd); check_val("rd_id", {24'd0, rd}, 32'h96);
    check_val("tx_cleared_after_cs", {24'd0, bus.tx_byte}, 32'h0);
    read_reg(3'd1, rd); check_val("rd_period_rst", {24'd0, rd}, 32'hFF);
    read_reg(3'd6, rd); check_val("rd_status_rst", {24'd0, rd}, 32'h00);

    // Shadow writes, then commit
    write_reg(3'd0, 8'h0A);
    write_reg(3'd1, 8'h64);
    write_reg(3'd3, 8'h40);
    check_val("duty1_pre_commit", {24'd0, pwm_duty[15:8]}, 32'h00);
    check_val("period_pre_commit", {24'd0, pwm_period}, 32'hFF);
    read_reg(3'd3, rd); check_val("rd_duty1_shadow", {24'd0, rd}, 32'h40);
    read_reg(3'd6, rd); check_val("status_pending", {24'd0, rd}, 32'h80);
    commit();
    check_val("duty1_post_commit", {24'd0, pwm_duty[15:8]}, 32'h40);
    check_val("en_post_commit", {28'd0, pwm_en}, 32'hA);
    check_val("period_post_commit", {24'd0, pwm_period}, 32'h64);
    read_reg(3'd6, rd); check_val("status_cleared", {24'd0, rd}, 32'h00);

    // Illegal command: error pulse, subsequent bytes drained
    cs_low();
    send_byte(8'h48);
    check_val("cmd_err_pulse", {31'd0, cmd_err}, 32'h1);
    send_byte(8'h81);
    check_val("cmd_err_low", {31'd0, cmd_err}, 32'h0);
    send_byte(8'h55);
    check_val("drain_tx_byte", {24'd0, bus.tx_byte}, 32'h0);
    check_val("drain_no_tx_valid", {31'd0, bus.tx_valid}, 32'h0);
    cs_high();
    read_reg(3'd6, rd); check_val("status_err1", {24'd0, rd}, 32'h01);
    read_reg(3'd1, rd); check_val("period_not_written", {24'd0, rd}, 32'h64);
    for (int i = 0; i < 19; i++) begin
      cs_low();
      send_byte(8'h48);
      cs_high();
    end
    read_reg(3'd6, rd); check_val("status_err_sat", {24'd0, rd}, 32'h0F);

    // Write coinciding with commit
    write_reg(3'd4, 8'h77);
    cs_low();
    send_byte(8'h82);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h5A;
    cfg_commit   = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    cfg_commit   = 1'b0;
    cs_high();
    check_val("duty0_unchanged", {24'd0, pwm_duty[7:0]}, 32'h00);
    check_val("duty2_committed", {24'd0, pwm_duty[23:16]}, 32'h77);
    read_reg(3'd6, rd); check_val("status_still_pending", {24'd0, rd}, 32'h8F);
    commit();
    check_val("duty0_next_commit", {24'd0, pwm_duty[7:0]}, 32'h5A);
    read_reg(3'd6, rd); check_val("status_after_commit2", {24'd0, rd}, 32'h0F);

    // cs_n abort: read leaves tx_byte, cs_n clears it
    cs_low();
    send_byte(8'h07);
    check_val("tx_id_held", {24'd0, bus.tx_byte}, 32'h96);
    bus.cs_n = 1'b1;
    tick();
    check_val("tx_cleared_on_cs", {24'd0, bus.tx_byte}, 32'h0);
    tick();

    // cs_n raised between command and data; byte while cs_n high ignored
    cs_low();
    send_byte(8'h81);
    bus.cs_n     = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h33;
    tick();
    bus.rx_valid = 1'b0;
    check_val("abort_tx_byte", {24'd0, bus.tx_byte}, 32'h0);
    tick();
    read_reg(3'd1, rd); check_val("abort_period_kept", {24'd0, rd}, 32'h64);
    read_reg(3'd6, rd); check_val("abort_no_pending", {24'd0, rd}, 32'h0F);

    // Burst starting at read-only address 6
    cs_low();
    send_byte(8'h86);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    cs_high();
`ifdef SPI_PWM_AUTOINC_EN
    read_reg(3'd0, rd); check_val("burst_ctrl", {24'd0, rd}, 32'h03);
    read_reg(3'd6, rd); check_val("burst_status", {24'd0, rd}, 32'h8F);
`else
    read_reg(3'd0, rd); check_val("burst_ctrl", {24'd0, rd}, 32'h0A);
    read_reg(3'd6, rd); check_val("burst_status", {24'd0, rd}, 32'h0F);
`endif
    read_reg(3'd7, rd); check_val("burst_id", {24'd0, rd}, 32'h96);

    // Reset overrides concurrent activity
    bus.cs_n     = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h81;
    cfg_commit   = 1'b1;
    rst          = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    cfg_commit   = 1'b0;
    bus.cs_n     = 1'b1;
    rst          = 1'b0;
    tick();
    check_val("rst2_period", {24'd0, pwm_period}, 32'hFF);
    check_val("rst2_en", {28'd0, pwm_en}, 32'h0);
    check_val("rst2_duty", pwm_duty, 32'h0);
    check_val("rst2_tx_byte", {24'd0, bus.tx_byte}, 32'h0);
    read_reg(3'd6, rd); check_val("rst2_status", {24'd0, rd}, 32'h00);
    read_reg(3'd1, rd); check_val("rst2_rd_period", {24'd0, rd}, 32'hFF);
    read_reg(3'd2, rd); check_val("rst2_rd_duty0", {24'd0, rd}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_pwm_regctl.md
SPI_PWM_REGCTL -- requirements
Module: spi_pwm_regctl

Interface
REQ-001 clk  in  1  single clock; all state changes on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 cs_n  in  1  SPI chip select, active low, already synchronised to clk.
REQ-004 rx_valid  in  1  one-cycle pulse; rx_byte holds a complete received SPI byte.
REQ-005 rx_byte  in  8  received byte, MSB first as shifted.
REQ-006 cfg_commit  in  1  one-cycle pulse from the PWM core at period end.
REQ-007 tx_byte  out  8  byte the SPI shifter sends on the next frame.
REQ-008 tx_valid  out  1  one-cycle pulse; tx_byte was updated this cycle.
REQ-009 pwm_en  out  4  active per-channel enables.
REQ-010 pwm_period  out  8  active PWM period.
REQ-011 pwm_duty  out  32  active duties; channel n at bits [8n+7:8n].
REQ-012 cmd_err  out  1  one-cycle pulse on an illegal command byte.

Function
REQ-013 Shadow register map: 0 CTRL[3:0] (R/W); 1 PERIOD (R/W); 2..5 DUTY0..3 (R/W); 6 STATUS (RO); 7 ID (RO, reads 0x96).
REQ-014 STATUS: bit7 = pending flag; bits[3:0] = error count, saturating at 15; other bits read 0.
REQ-015 FSM states: IDLE, CMD, WDATA, RDATA, DRAIN.
REQ-016 Transitions are as follows:
- IDLE->CMD when cs_n is low.
- CMD takes the first rx_valid byte as the command.
- bit7=1 with bits[6:3]=0: go to WDATA.
- bit7=0 with bits[6:3]=0: go to RDATA.
- bits[6:3]!=0: pulse cmd_err, increment the error count and go to DRAIN.
REQ-017 Command byte bits[2:0] become the current address.
REQ-018 WDATA: each rx_valid byte is written to shadow[addr] in that cycle; writes to addresses 6 and 7 are silently dropped.
REQ-019 On accepting a read command, in the cycle after rx_valid: tx_byte = shadow[addr] and tx_valid is pulsed.
REQ-020 DRAIN: all rx_valid bytes are ignored and tx_byte = 0x00.
REQ-021 cs_n high in any state: return to IDLE in the next cycle and drop any in-flight byte.
- Writes already completed are kept.
- tx_byte clears to 0x00.
REQ-022 rx_valid while cs_n is high is ignored.
REQ-023 Any accepted write to addresses 0..5 sets the pending flag.
REQ-024 cfg_commit with pending=1: in the same edge, copy shadow CTRL/PERIOD/DUTY into the active outputs and clear pending.
REQ-025 cfg_commit with pending=0 has no effect.
REQ-026 Simultaneous write and cfg_commit: the commit copies the pre-write shadow, and pending stays 1.
REQ-027 Reads return shadow values, not active values.

Reset
REQ-028 rst=1 sets:
- FSM to IDLE.
- Shadow and active CTRL to 0, PERIOD to 0xFF, DUTY to 0x00.
- Pending to 0 and error count to 0.
- tx_byte to 0x00; tx_valid and cmd_err to 0.
REQ-029 rst overrides cs_n, rx_valid and cfg_commit in the same cycle.

Configuration
REQ-030 Macro SPI_PWM_AUTOINC_EN:
- Defined: after each data byte in WDATA, and after each rx_valid in RDATA, the address increments by 1 and wraps 7->0.
- Defined, RDATA: every rx_valid reloads tx_byte with shadow[new addr] and pulses tx_valid.
- Undefined: WDATA accepts exactly one data byte, then goes to DRAIN.
- Undefined: RDATA goes to DRAIN on the next rx_valid.

Verification
REQ-031 Reset, then read addr 7 (0x07) -> tx_byte=0x96 and a tx_valid pulse; read addr 1 -> 0xFF.
REQ-032 Write 0x83,0x40 then cfg_commit -> pwm_duty[15:8]=0x40 only after the commit; STATUS bit7 reads 1 before the commit and 0 after.
REQ-033 Command byte 0x48 -> cmd_err pulse, STATUS reads 0x01, and following bytes are ignored until cs_n rises; 20 bad commands -> count stays 15.
REQ-034 Write to addr 2 in the same cycle as cfg_commit -> active duty0 unchanged, pending=1, and the next cfg_commit applies it.
REQ-035 cs_n raised between the command and data bytes of a write -> shadow unchanged, FSM in IDLE, tx_byte=0x00.
REQ-036 With SPI_PWM_AUTOINC_EN, write 0x86,0x11,0x22,0x33 -> addresses 6 and 7 dropped, addr 0 CTRL=0x3 (low 4 bits of 0x33). Without the macro -> only the 0x11 write attempt, dropped, and the rest drained.
